// File: rtl/hex_lights_multi_driver_if.sv
// hex_lights_multi_driver_if: light codes in, HEX segments and status out
interface hex_lights_multi_driver_if #(parameter int NUM_CH = 4);
    logic [4*NUM_CH-1:0] colour;
    logic                flash_left;
    logic                lamp_test;
    logic                fault_clr;
    logic [7*NUM_CH-1:0] hex_segments;
    logic                fault;
    logic                test_busy;
    modport master (output colour, flash_left, lamp_test, fault_clr, input hex_segments, fault, test_busy);
    modport slave (input colour, flash_left, lamp_test, fault_clr, output hex_segments, fault, test_busy);
endinterface

// File: rtl/hex_lights_multi_driver.sv
// hex_lights_multi_driver: registered multi-digit traffic-light decoder with blink, lamp test and fault latch
module hex_lights_multi_driver #(
    parameter int NUM_CH           = 4,
    parameter int BLINK_DIV        = 25_000_000,
    parameter int FAULT_PERSIST    = 8,
    parameter int LAMP_TEST_CYCLES = 50_000_000
) (
    input logic                        clk,
    input logic                        reset,
    hex_lights_multi_driver_if.slave   io_bus
);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int PW = $clog2(FAULT_PERSIST + 1);
    localparam int LW = $clog2(LAMP_TEST_CYCLES + 1);

    typedef enum logic [1:0] {NORMAL, LAMP_TEST, FAULT} state_t;

    state_t              r_state, w_state_next;
    logic [BW-1:0]       r_blink_cnt, w_blink_cnt_next;
    logic                r_phase, w_phase_next, w_wrap, w_fault_entry;
    logic [LW-1:0]       r_lamp_cnt, w_lamp_cnt_next;
    logic [PW-1:0]       r_persist [NUM_CH];
    logic [PW-1:0]       w_persist_next [NUM_CH];
    logic [NUM_CH-1:0]   w_illegal, w_hit;
    logic [7*NUM_CH-1:0] r_hex, w_hex_next;

    function automatic logic [6:0] decode(input logic [3:0] code);
        return code == 4'h0 ? 7'h7F : code == 4'h1 ? 7'h7E : code == 4'h2 ? 7'h3F :
               code == 4'h4 ? 7'h77 : code == 4'h8 ? 7'h39 : 7'h00;
    endfunction

    // Per-channel illegal detection; persistence counts only run in NORMAL and saturate
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_illegal[c] = $countones(io_bus.colour[4*c +: 4]) > 1;
            w_persist_next[c] = (r_state != NORMAL || !w_illegal[c]) ? '0 :
                                r_persist[c] == PW'(FAULT_PERSIST) ? r_persist[c] : r_persist[c] + 1'b1;
            w_hit[c] = w_persist_next[c] == PW'(FAULT_PERSIST);
        end
    end

    // Next-state logic; lamp counter holds remaining cycles after the current one
    always_comb begin
        w_state_next    = r_state;
        w_lamp_cnt_next = r_lamp_cnt;
        case (r_state)
            NORMAL: begin
                if (|w_hit) begin
                    w_state_next = FAULT;
                end else if (io_bus.lamp_test) begin
                    w_state_next    = LAMP_TEST;
                    w_lamp_cnt_next = LW'(LAMP_TEST_CYCLES - 1);
                end
            end
            LAMP_TEST: begin
                if (r_lamp_cnt == '0) w_state_next = NORMAL;
                else w_lamp_cnt_next = r_lamp_cnt - 1'b1;
            end
            FAULT: if (io_bus.fault_clr && !(|w_illegal)) w_state_next = NORMAL;
            default: w_state_next = NORMAL;
        endcase
    end

    // Blink generator restarts lit on every FAULT entry so the first amber interval is full length
    always_comb begin
        w_fault_entry    = w_state_next == FAULT && r_state != FAULT;
        w_wrap           = r_blink_cnt == BW'(BLINK_DIV - 1);
        w_blink_cnt_next = (w_fault_entry || w_wrap) ? '0 : r_blink_cnt + 1'b1;
        w_phase_next     = w_fault_entry ? 1'b0 : r_phase ^ w_wrap;
    end

    // Segment pattern for the state and blink phase that will hold after this edge
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_hex_next[7*c +: 7] = w_state_next == LAMP_TEST ? 7'h00 :
                                   w_state_next == FAULT ? (w_phase_next ? 7'h7F : 7'h3F) :
                                   (io_bus.flash_left && io_bus.colour[4*c +: 4] == 4'h8 && w_phase_next) ? 7'h7F :
                                   decode(io_bus.colour[4*c +: 4]);
        end
    end

    // State, counters and registered segment outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= NORMAL;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_lamp_cnt  <= '0;
            r_hex       <= '1;
            for (int c = 0; c < NUM_CH; c++) r_persist[c] <= '0;
        end else begin
            r_state     <= w_state_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_phase     <= w_phase_next;
            r_lamp_cnt  <= w_lamp_cnt_next;
            r_hex       <= w_hex_next;
            for (int c = 0; c < NUM_CH; c++) r_persist[c] <= w_persist_next[c];
        end
    end

    assign io_bus.hex_segments = r_hex;
    assign io_bus.fault        = r_state == FAULT;
    assign io_bus.test_busy    = r_state == LAMP_TEST;
endmodule

// File: tb/tb_hex_lights_multi_driver.sv
// tb_hex_lights_multi_driver: directed checks of decode, flashing, fault latch and lamp test
module tb_hex_lights_multi_driver;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    hex_lights_multi_driver_if #(.NUM_CH(2)) bus ();

    hex_lights_multi_driver #(
        .NUM_CH(2), .BLINK_DIV(4), .FAULT_PERSIST(3), .LAMP_TEST_CYCLES(5)
    ) dut (
        .clk(clk), .reset(reset), .io_bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic f, input logic b);
        chk({tag, "_fault"}, 14'(bus.fault), 14'(f));
        chk({tag, "_busy"}, 14'(bus.test_busy), 14'(b));
    endtask

    initial begin
        bus.colour = 8'h12; bus.flash_left = 0; bus.lamp_test = 0; bus.fault_clr = 0;
        reset = 1;
        tick(); tick();
        chk("rst_hex", bus.hex_segments, 14'h3FFF);
        chk_flags("rst", 0, 0);
        reset = 0;
        tick();
        chk("first_decode", bus.hex_segments, {7'h7E, 7'h3F});
        bus.colour = 8'h48; bus.flash_left = 1;
        for (int k = 2; k <= 11; k++) begin
            tick();
            chk($sformatf("flash_e%0d", k), bus.hex_segments, {7'h77, (k >= 4 && k <= 7) ? 7'h7F : 7'h39});
        end
        bus.flash_left = 0;
        tick(); chk("steady_left_a", bus.hex_segments, {7'h77, 7'h39});
        tick(); chk("steady_left_b", bus.hex_segments, {7'h77, 7'h39});
        bus.colour = 8'h43;
        tick(); chk("illegal_a", bus.hex_segments, {7'h77, 7'h00}); chk_flags("illegal_a", 0, 0);
        tick(); chk("illegal_b", bus.hex_segments, {7'h77, 7'h00}); chk_flags("illegal_b", 0, 0);
        bus.colour = 8'h41;
        tick(); chk("recover", bus.hex_segments, {7'h77, 7'h7E}); chk_flags("recover", 0, 0);
        bus.colour = 8'h43;
        tick(); chk("pre_fault_a", bus.hex_segments, {7'h77, 7'h00}); chk_flags("pre_fault_a", 0, 0);
        tick(); chk("pre_fault_b", bus.hex_segments, {7'h77, 7'h00}); chk_flags("pre_fault_b", 0, 0);
        tick(); chk("fault_entry", bus.hex_segments, {7'h3F, 7'h3F}); chk_flags("fault_entry", 1, 0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("fault_blink_%0d", i), bus.hex_segments, (i >= 4) ? {7'h7F, 7'h7F} : {7'h3F, 7'h3F});
            chk_flags($sformatf("fault_blink_%0d", i), 1, 0);
        end
        bus.fault_clr = 1;
        tick(); chk_flags("clr_blocked", 1, 0); chk("clr_blocked_hex", bus.hex_segments, {7'h3F, 7'h3F});
        bus.fault_clr = 0; bus.colour = 8'h44;
        tick(); chk_flags("fixed_no_clr", 1, 0);
        bus.fault_clr = 1;
        tick(); chk_flags("fault_exit", 0, 0); chk("fault_exit_hex", bus.hex_segments, {7'h77, 7'h77});
        bus.fault_clr = 0; bus.lamp_test = 1;
        tick(); chk("lamp_1", bus.hex_segments, 14'h0000); chk_flags("lamp_1", 0, 1);
        for (int i = 2; i <= 5; i++) begin
            bus.colour = 8'h43; bus.lamp_test = (i == 3);
            tick();
            chk($sformatf("lamp_%0d", i), bus.hex_segments, 14'h0000);
            chk_flags($sformatf("lamp_%0d", i), 0, 1);
        end
        bus.lamp_test = 0; bus.colour = 8'h41;
        tick(); chk("lamp_done", bus.hex_segments, {7'h77, 7'h7E}); chk_flags("lamp_done", 0, 0);
        bus.lamp_test = 1;
        tick(); bus.lamp_test = 0; chk_flags("lamp_again", 0, 1);
        reset = 1;
        tick(); chk("rst_lamp_hex", bus.hex_segments, 14'h3FFF); chk_flags("rst_lamp", 0, 0);
        reset = 0;
        tick(); chk("after_rst_lamp", bus.hex_segments, {7'h77, 7'h7E});
        bus.colour = 8'h43;
        tick(); tick();
        bus.lamp_test = 1;
        tick(); bus.lamp_test = 0;
        chk_flags("fault_over_lamp", 1, 0); chk("fault_over_lamp_hex", bus.hex_segments, {7'h3F, 7'h3F});
        reset = 1;
        tick(); chk("rst_fault_hex", bus.hex_segments, 14'h3FFF); chk_flags("rst_fault", 0, 0);
        reset = 0; bus.colour = 8'h41;
        tick(); chk("after_rst_fault", bus.hex_segments, {7'h77, 7'h7E}); chk_flags("after_rst_fault", 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hex_lights_multi_driver.md
# hex_lights_multi_driver

Registered, multi-channel successor to the single-digit traffic-light hex decoder. Drives NUM_CH active-low seven-segment digits, one per intersection approach, from one-hot light codes. Adds left-arrow flashing, a timed lamp-test mode and a latched fault mode (all digits blinking amber) entered when any channel holds an illegal code for too long. Sits between the traffic-light controller FSM and the board's HEX pins.

## Interface
- NUM_CH, 4: number of channels/digits (1..8).
- BLINK_DIV, 25_000_000: clock cycles per blink half-period (≥2).
- FAULT_PERSIST, 8: consecutive illegal-code cycles on one channel that trigger FAULT (≥1).
- LAMP_TEST_CYCLES, 50_000_000: duration of the lamp test in cycles (≥1).

- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- colour  input  4*NUM_CH  per channel [4c+3:4c] = {left, green, amber, red}, one-hot or zero.
- flash_left  input  1  when 1, LEFT codes blink instead of showing steadily.
- lamp_test  input  1  request lamp test; level sampled each edge.
- fault_clr  input  1  request exit from FAULT.
- hex_segments  output  7*NUM_CH  per channel [7c+6:7c], active-low segments {g,f,e,d,c,b,a}.
- fault  output  1  high while in FAULT.
- test_busy  output  1  high while in LAMP_TEST.

## Operation
- Per-channel decode (active-low): OFF 0000→1111111; RED 0001→1111110; AMBER 0010→0111111; GREEN 0100→1110111; LEFT 1000→0111001; any other code is illegal→0000000.
- Blink generator: counter 0..BLINK_DIV-1, wraps and toggles blink_phase (0 = lit, 1 = dark). Free-running; reset to count 0, phase 0 on reset and on every entry to FAULT.
- FSM states NORMAL, LAMP_TEST, FAULT; reset → NORMAL.
- NORMAL: each digit = decode of its channel; if flash_left=1 and the code is LEFT and blink_phase=1, the digit is 1111111.
  - Per-channel persistence counter: increments on each edge where the code is illegal, clears to 0 on a legal code. Saturates at FAULT_PERSIST.
  - If any counter reaches FAULT_PERSIST → FAULT (takes priority over lamp_test in the same cycle).
  - Else if lamp_test=1 → LAMP_TEST, duration counter loaded with LAMP_TEST_CYCLES.
- LAMP_TEST: all digits 0000000; persistence counters held at 0; lamp_test, fault_clr ignored (no retrigger). After exactly LAMP_TEST_CYCLES edges in the state → NORMAL.
- FAULT: all digits show AMBER (0111111) while blink_phase=0 and 1111111 while blink_phase=1, regardless of colour/flash_left. lamp_test ignored. On an edge with fault_clr=1 and no channel currently illegal → NORMAL, persistence counters cleared. fault_clr with any illegal channel is ignored (stay in FAULT).
- Reset mid-operation (any state): next edge forces NORMAL, all counters 0, outputs to reset values.

## Timing
- Reset values: hex_segments all 1 (all digits blank), fault=0, test_busy=0.
- All outputs registered: an input applied before edge n is reflected in outputs after edge n (1-cycle latency).
- Fault: channel illegal on edges n..n+FAULT_PERSIST-1 → after edge n+FAULT_PERSIST-1 fault=1 and digits show amber-on. Illegal digit shows 0000000 for the FAULT_PERSIST-1 preceding cycles.
- Fault blink: first amber-on interval lasts BLINK_DIV cycles, then alternating BLINK_DIV-cycle dark/on intervals.
- Lamp test: lamp_test high before edge n → test_busy=1 and all segments lit after edge n through edge n+LAMP_TEST_CYCLES-1; NORMAL output after edge n+LAMP_TEST_CYCLES.
- FAULT exit: after the edge sampling a valid fault_clr, fault=0 and decoded digits appear.

## Test plan
Parameters NUM_CH=2, BLINK_DIV=4, FAULT_PERSIST=3, LAMP_TEST_CYCLES=5.
- Reset held 2 cycles with colour=8'h12 → hex_segments=14'h3FFF, fault=0, test_busy=0; one edge after release, ch0=0111111, ch1=1111110.
- colour=8'h48 (ch0 LEFT, ch1 GREEN), flash_left=1 → ch0 alternates 0111001/1111111 every 4 cycles; ch1 steady 1110111; flash_left=0 → ch0 steady.
- ch0 colour=4'h3 for 2 cycles then 4'h1 → ch0 0000000 for 2 cycles, then 1111110, fault stays 0; ch0=4'h3 for 3 cycles → fault=1, both digits 0111111 for 4 cycles, 1111111 for 4, repeating.
- In FAULT: fault_clr=1 while ch0 still 4'h3 → remains FAULT; fix ch0 to 4'h4, pulse fault_clr → fault=0, ch0=1110111 next cycle.
- lamp_test 1-cycle pulse → test_busy=1 and all segments 0 for exactly 5 cycles; second pulse mid-test → no extension; illegal codes during test do not cause FAULT.
- Reset asserted during LAMP_TEST and during FAULT → next edge outputs blank, fault=0, test_busy=0.
